// File: rtl/euler1_pkg.sv
// Shared types and constants for the Euler-1 run controller and its slice gatherer.
package euler1_pkg;

  localparam int SLICE_W    = 6;
  localparam int NUM_SLICES = 3;
  localparam int RESULT_W   = SLICE_W * NUM_SLICES;

  localparam logic [RESULT_W-1:0] EXPECTED_RESULT = 18'd233168;

  typedef enum logic [2:0] {
    IDLE,
    RESET_DUT,
    WAIT_VALID,
    READ,
    DONE
  } state_t;

endpackage

// File: rtl/euler1_slice_gather.sv
// Steps the core's slice mux, holds each select for SETTLE cycles and inserts
// the presented slice into the assembled result word.
module euler1_slice_gather
  import euler1_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                load,
  input  logic                step,
  input  logic                finish,
  input  logic [SLICE_W-1:0]  slice,
  output logic [1:0]          mux_sel,
  output logic [RESULT_W-1:0] result,
  output logic                last
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [SET_W-1:0] settle_cnt;
  logic             capture;

  assign capture = step && (settle_cnt == SET_W'(SETTLE - 1));
  assign last    = capture && (mux_sel == 2'(NUM_SLICES - 1));

  // The select is held on the final slice through DONE and only returns to 0 when DONE exits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mux_sel    <= '0;
      settle_cnt <= '0;
      result     <= '0;
    end else begin
      if (clear) begin
        result <= '0;
      end
      if (load || finish) begin
        mux_sel    <= '0;
        settle_cnt <= '0;
      end else if (step) begin
        if (capture) begin
          for (int i = 0; i < NUM_SLICES; i++) begin
            if (mux_sel == 2'(i)) begin
              result[i*SLICE_W +: SLICE_W] <= slice;
            end
          end
          settle_cnt <= '0;
          if (!last) begin
            mux_sel <= mux_sel + 2'd1;
          end
        end else begin
          settle_cnt <= settle_cnt + SET_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/euler1_run_ctrl.sv
// Run sequencer for the Euler-1 core: pulses the core reset, waits for valid
// with a timeout, gathers the result slices and reports with a done pulse.
module euler1_run_ctrl
  import euler1_pkg::*;
#(
  parameter int RST_CYCLES = 1,
  parameter int TIMEOUT    = 600,
  parameter int SETTLE     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                timeout_err,
  output logic [RESULT_W-1:0] result,
  output logic                dut_rst,
  output logic [1:0]          mux_sel,
  input  logic                dut_valid,
  input  logic [SLICE_W-1:0]  dut_slice
);

  localparam int CNT_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_slice;

  assign accept = (state == IDLE) && start;

  // The core stays in reset whenever the controller itself is in reset.
  assign dut_rst = rst | (state == RESET_DUT);

  euler1_slice_gather #(
    .SETTLE (SETTLE)
  ) u_gather (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .load    ((state == WAIT_VALID) && dut_valid),
    .step    (state == READ),
    .finish  (state == DONE),
    .slice   (dut_slice),
    .mux_sel (mux_sel),
    .result  (result),
    .last    (last_slice)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RESET_DUT;
            busy        <= 1'b1;
            timeout_err <= 1'b0;
            cnt         <= '0;
          end
        end
        RESET_DUT: begin
          if (cnt == CNT_W'(RST_CYCLES - 1)) begin
            state <= WAIT_VALID;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // Valid wins over the timeout so a late valid on the final cycle still succeeds.
        WAIT_VALID: begin
          if (dut_valid) begin
            state <= READ;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state       <= DONE;
            timeout_err <= 1'b1;
            done        <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        READ: begin
          if (last_slice) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_euler1_run_ctrl.sv
// Self-checking bench for euler1_run_ctrl with a behavioural Euler-1 core model.
module tb_euler1_run_ctrl;
  import euler1_pkg::*;

  localparam int RST_C = 1;
  localparam int TMO   = 600;
  localparam int SET   = 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                busy;
  logic                done;
  logic                timeout_err;
  logic [RESULT_W-1:0] result;
  logic                dut_rst;
  logic [1:0]          mux_sel;
  logic                dut_valid;
  logic [SLICE_W-1:0]  dut_slice;

  int total = 0;
  int bad   = 0;

  logic [SLICE_W-1:0] slice_tab [4];
  int valid_delay = 0;
  bit valid_en    = 1'b0;
  int since_rst   = 0;

  always #5 clk = ~clk;

  // Core model: valid rises valid_delay cycles after its reset falls; slice follows mux_sel.
  always @(posedge clk) begin
    if (dut_rst) since_rst <= 0;
    else         since_rst <= since_rst + 1;
  end
  assign dut_valid = valid_en && !dut_rst && (since_rst >= valid_delay);
  assign dut_slice = slice_tab[mux_sel];

  euler1_run_ctrl #(
    .RST_CYCLES (RST_C),
    .TIMEOUT    (TMO),
    .SETTLE     (SET)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .result      (result),
    .dut_rst     (dut_rst),
    .mux_sel     (mux_sel),
    .dut_valid   (dut_valid),
    .dut_slice   (dut_slice)
  );

  function automatic logic [RESULT_W-1:0] ref_result(input int s0, input int s1, input int s2);
    return RESULT_W'(s0 + s1 * 64 + s2 * 4096);
  endfunction

  function automatic int ref_busy_ok(input int delay);
    return RST_C + (delay + 1) + NUM_SLICES * SET + 1;
  endfunction

  task automatic do_run(input int delay, input bit ven,
                        input logic [5:0] s0, input logic [5:0] s1, input logic [5:0] s2,
                        input int pulse_at,
                        output int busy_cyc, output int done_cnt, output int rst_cyc,
                        output logic [RESULT_W-1:0] res, output logic terr,
                        output bit mux_moved, output bit hung);
    valid_delay  = delay;
    valid_en     = ven;
    slice_tab[0] = s0;
    slice_tab[1] = s1;
    slice_tab[2] = s2;
    slice_tab[3] = '0;
    busy_cyc  = 0;
    done_cnt  = 0;
    rst_cyc   = 0;
    res       = '1;
    terr      = 1'bx;
    mux_moved = 1'b0;
    hung      = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!busy) begin
        hung = 1'b0;
        break;
      end
      busy_cyc++;
      if (done) begin
        done_cnt++;
        res  = result;
        terr = timeout_err;
      end
      if (dut_rst) rst_cyc++;
      if (mux_sel != 2'd0) mux_moved = 1'b1;
      start = (pulse_at >= 0) && (busy_cyc == pulse_at);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_terr got=%b want=0", timeout_err); end
    total++; if (result !== '0) begin bad++; $display("[TB] FAIL reset_result got=%0d want=0", result); end
    total++; if (mux_sel !== 2'd0) begin bad++; $display("[TB] FAIL reset_mux got=%0d want=0", mux_sel); end
    total++; if (dut_rst !== 1'b1) begin bad++; $display("[TB] FAIL reset_dut_rst got=%b want=1", dut_rst); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (dut_rst !== 1'b0) begin bad++; $display("[TB] FAIL idle_dut_rst got=%b want=0", dut_rst); end
  endtask

  task automatic test_nominal();
    int bc, dc, rc;
    logic [RESULT_W-1:0] r;
    logic t;
    bit mm, h;
    do_run(10, 1'b1, 6'd16, 6'd59, 6'd56, -1, bc, dc, rc, r, t, mm, h);
    total++; if (h) begin bad++; $display("[TB] FAIL nominal_hang got=busy_stuck want=finished"); end
    total++; if (r !== EXPECTED_RESULT) begin bad++; $display("[TB] FAIL nominal_result got=%0d want=%0d", r, EXPECTED_RESULT); end
    total++; if (t !== 1'b0) begin bad++; $display("[TB] FAIL nominal_terr got=%b want=0", t); end
    total++; if (dc !== 1) begin bad++; $display("[TB] FAIL nominal_done_count got=%0d want=1", dc); end
    total++; if (bc !== ref_busy_ok(10)) begin bad++; $display("[TB] FAIL nominal_busy got=%0d want=%0d", bc, ref_busy_ok(10)); end
    total++; if (rc !== RST_C) begin bad++; $display("[TB] FAIL nominal_dut_rst got=%0d want=%0d", rc, RST_C); end
    @(negedge clk);
    total++; if (result !== EXPECTED_RESULT) begin bad++; $display("[TB] FAIL nominal_hold got=%0d want=%0d", result, EXPECTED_RESULT); end
    total++; if (mux_sel !== 2'd0) begin bad++; $display("[TB] FAIL nominal_mux_idle got=%0d want=0", mux_sel); end
  endtask

  task automatic test_timeout();
    int bc, dc, rc;
    logic [RESULT_W-1:0] r;
    logic t;
    bit mm, h;
    do_run(0, 1'b0, 6'd16, 6'd59, 6'd56, -1, bc, dc, rc, r, t, mm, h);
    total++; if (h) begin bad++; $display("[TB] FAIL timeout_hang got=busy_stuck want=finished"); end
    total++; if (bc !== RST_C + TMO + 1) begin bad++; $display("[TB] FAIL timeout_busy got=%0d want=%0d", bc, RST_C + TMO + 1); end
    total++; if (t !== 1'b1) begin bad++; $display("[TB] FAIL timeout_terr got=%b want=1", t); end
    total++; if (r !== '0) begin bad++; $display("[TB] FAIL timeout_result got=%0d want=0", r); end
    total++; if (dc !== 1) begin bad++; $display("[TB] FAIL timeout_done_count got=%0d want=1", dc); end
    total++; if (mm !== 1'b0) begin bad++; $display("[TB] FAIL timeout_mux_moved got=%b want=0", mm); end
    @(negedge clk);
    total++; if (timeout_err !== 1'b1) begin bad++; $display("[TB] FAIL timeout_terr_hold got=%b want=1", timeout_err); end
  endtask

  task automatic test_timeout_edge();
    int bc, dc, rc;
    logic [RESULT_W-1:0] r;
    logic t;
    bit mm, h;
    do_run(TMO - 1, 1'b1, 6'd16, 6'd59, 6'd56, -1, bc, dc, rc, r, t, mm, h);
    total++; if (h) begin bad++; $display("[TB] FAIL edge_hang got=busy_stuck want=finished"); end
    total++; if (r !== EXPECTED_RESULT) begin bad++; $display("[TB] FAIL edge_result got=%0d want=%0d", r, EXPECTED_RESULT); end
    total++; if (t !== 1'b0) begin bad++; $display("[TB] FAIL edge_terr got=%b want=0", t); end
    total++; if (bc !== ref_busy_ok(TMO - 1)) begin bad++; $display("[TB] FAIL edge_busy got=%0d want=%0d", bc, ref_busy_ok(TMO - 1)); end
  endtask

  task automatic test_back_to_back();
    int phase = 0;
    int rst_between = 0;
    int idle_gap = 0;
    bit finished = 1'b0;
    logic [RESULT_W-1:0] first_res = '1;
    logic [RESULT_W-1:0] second_res = '1;
    valid_delay  = 10;
    valid_en     = 1'b1;
    slice_tab[0] = 6'd16;
    slice_tab[1] = 6'd59;
    slice_tab[2] = 6'd56;
    slice_tab[3] = '0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (phase == 1) begin
        if (dut_rst) rst_between++;
        if (!busy) idle_gap++;
      end
      if (done && phase == 0) begin
        first_res    = result;
        slice_tab[0] = 6'd1;
        slice_tab[1] = 6'd2;
        slice_tab[2] = 6'd3;
        phase        = 1;
      end else if (done && phase == 1) begin
        second_res = result;
        finished   = 1'b1;
        break;
      end
    end
    start = 1'b0;
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    total++; if (!finished) begin bad++; $display("[TB] FAIL b2b_hang got=no_second_done want=second_done"); end
    total++; if (first_res !== EXPECTED_RESULT) begin bad++; $display("[TB] FAIL b2b_first got=%0d want=%0d", first_res, EXPECTED_RESULT); end
    total++; if (second_res !== ref_result(1, 2, 3)) begin bad++; $display("[TB] FAIL b2b_second got=%0d want=%0d", second_res, ref_result(1, 2, 3)); end
    total++; if (rst_between !== RST_C) begin bad++; $display("[TB] FAIL b2b_dut_rst got=%0d want=%0d", rst_between, RST_C); end
    total++; if (idle_gap !== 1) begin bad++; $display("[TB] FAIL b2b_idle_gap got=%0d want=1", idle_gap); end
  endtask

  task automatic test_reset_mid_read();
    int bc, dc, rc;
    logic [RESULT_W-1:0] r;
    logic t;
    bit mm, h;
    bit seen = 1'b0;
    valid_delay  = 3;
    valid_en     = 1'b1;
    slice_tab[0] = 6'd16;
    slice_tab[1] = 6'd59;
    slice_tab[2] = 6'd56;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (mux_sel == 2'd1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++; if (!seen) begin bad++; $display("[TB] FAIL midrst_reach got=no_mux1 want=mux1"); end
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy got=%b want=0", busy); end
    total++; if (result !== '0) begin bad++; $display("[TB] FAIL midrst_result got=%0d want=0", result); end
    total++; if (mux_sel !== 2'd0) begin bad++; $display("[TB] FAIL midrst_mux got=%0d want=0", mux_sel); end
    total++; if (dut_rst !== 1'b1) begin bad++; $display("[TB] FAIL midrst_dut_rst got=%b want=1", dut_rst); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL midrst_done got=%b want=0", done); end
    @(negedge clk);
    rst = 1'b0;
    do_run(4, 1'b1, 6'd7, 6'd8, 6'd9, -1, bc, dc, rc, r, t, mm, h);
    total++; if (h) begin bad++; $display("[TB] FAIL midrst_hang got=busy_stuck want=finished"); end
    total++; if (r !== ref_result(7, 8, 9)) begin bad++; $display("[TB] FAIL midrst_rerun got=%0d want=%0d", r, ref_result(7, 8, 9)); end
    total++; if (bc !== ref_busy_ok(4)) begin bad++; $display("[TB] FAIL midrst_busy_len got=%0d want=%0d", bc, ref_busy_ok(4)); end
  endtask

  task automatic test_ignored_start();
    int bc, dc, rc;
    logic [RESULT_W-1:0] r;
    logic t;
    bit mm, h;
    do_run(10, 1'b1, 6'd16, 6'd59, 6'd56, 5, bc, dc, rc, r, t, mm, h);
    total++; if (h) begin bad++; $display("[TB] FAIL ignore_hang got=busy_stuck want=finished"); end
    total++; if (rc !== RST_C) begin bad++; $display("[TB] FAIL ignore_dut_rst got=%0d want=%0d", rc, RST_C); end
    total++; if (dc !== 1) begin bad++; $display("[TB] FAIL ignore_done_count got=%0d want=1", dc); end
    total++; if (r !== EXPECTED_RESULT) begin bad++; $display("[TB] FAIL ignore_result got=%0d want=%0d", r, EXPECTED_RESULT); end
    total++; if (bc !== ref_busy_ok(10)) begin bad++; $display("[TB] FAIL ignore_busy got=%0d want=%0d", bc, ref_busy_ok(10)); end
  endtask

  task automatic test_random();
    int bc, dc, rc, d;
    logic [RESULT_W-1:0] r;
    logic t;
    bit mm, h;
    logic [5:0] s0, s1, s2;
    for (int n = 0; n < 8; n++) begin
      d  = int'($urandom_range(0, 40));
      s0 = 6'($urandom);
      s1 = 6'($urandom);
      s2 = 6'($urandom);
      do_run(d, 1'b1, s0, s1, s2, -1, bc, dc, rc, r, t, mm, h);
      total++; if (h) begin bad++; $display("[TB] FAIL rand%0d_hang got=busy_stuck want=finished", n); end
      total++; if (r !== ref_result(s0, s1, s2)) begin bad++; $display("[TB] FAIL rand%0d_result got=%0d want=%0d", n, r, ref_result(s0, s1, s2)); end
      total++; if (t !== 1'b0) begin bad++; $display("[TB] FAIL rand%0d_terr got=%b want=0", n, t); end
      total++; if (bc !== ref_busy_ok(d)) begin bad++; $display("[TB] FAIL rand%0d_busy got=%0d want=%0d", n, bc, ref_busy_ok(d)); end
      total++; if (dc !== 1) begin bad++; $display("[TB] FAIL rand%0d_done_count got=%0d want=1", n, dc); end
    end
  endtask

  initial begin
    slice_tab[0] = '0;
    slice_tab[1] = '0;
    slice_tab[2] = '0;
    slice_tab[3] = '0;
    $display("[TB] starting euler1_run_ctrl checks");
    test_reset();
    test_nominal();
    test_timeout();
    test_timeout_edge();
    test_back_to_back();
    test_reset_mid_read();
    test_ignored_start();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/euler1_run_ctrl.md
Name: euler1_run_ctrl

Overview:
Sequencer for the Euler-1 accumulator core. It pulses the core's reset, then waits for `valid` with a bounded timeout. It then steps the core's 2-bit result-slice mux to assemble the full 18-bit answer, which it presents with a one-cycle done pulse. It sits between the top-level I/O pins (start/readback) and the core. A host therefore issues a single start and reads one word instead of hand-driving rst and mux_sel.

Parameters:
- RESULT_W, 18: width of the assembled result.
- SLICE_W, 6: width of each slice presented by the core.
- NUM_SLICES, 3: slices per result; RESULT_W = SLICE_W*NUM_SLICES.
- RST_CYCLES, 1: cycles dut_rst is held high per run (>=1).
- TIMEOUT, 600: maximum cycles spent in WAIT_VALID before aborting.
- SETTLE, 1: cycles mux_sel is held per slice before capture (>=1).

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: level; sampled only in IDLE.
- busy, out, 1: high from the cycle after start is accepted until DONE inclusive.
- done, out, 1: one-cycle pulse when the run ends (success or timeout).
- timeout_err, out, 1: set with done if valid never arrived; held until the next accepted start.
- result, out, RESULT_W: assembled value; held until the next accepted start.
- dut_rst, out, 1: reset to the core.
- mux_sel, out, 2: slice select to the core.
- dut_valid, in, 1: core's valid flag.
- dut_slice, in, SLICE_W: core's result slice for the current mux_sel.

Behaviour:
- Reset (async) values:
  - state=IDLE; busy=0, done=0, timeout_err=0, result=0, mux_sel=0.
  - Cycle, slice and settle counters = 0.
  - dut_rst = rst OR (state==RESET_DUT), so the core is held in reset while the controller is in reset.
- IDLE:
  - start=1 at an edge -> RESET_DUT.
  - On that same edge: result<=0, timeout_err<=0, cnt<=0.
- RESET_DUT:
  - dut_rst=1 for exactly RST_CYCLES cycles -> WAIT_VALID, cnt<=0.
- WAIT_VALID:
  - dut_valid=1 sampled -> READ, with k=0, mux_sel<=0, settle<=0.
  - Otherwise, if cnt==TIMEOUT-1 -> DONE with timeout_err<=1 and result left at 0.
  - Otherwise cnt<=cnt+1.
  - valid is checked before timeout, so valid arriving on the last cycle counts as success.
- READ:
  - mux_sel=k is held for SETTLE cycles.
  - On the edge ending the last settle cycle: result[k*SLICE_W +: SLICE_W] <= dut_slice.
  - If k==NUM_SLICES-1 -> DONE, else k<=k+1 and mux_sel<=k+1.
  - dut_valid is ignored in READ; a deassertion does not abort.
- DONE:
  - One cycle: done=1, busy=1 -> IDLE.
  - mux_sel returns to 0 on that edge.
- start while not in IDLE is ignored; start held high re-triggers a new run immediately after DONE.
- Latency, successful run: busy high for RST_CYCLES + W + NUM_SLICES*SETTLE + 1 cycles, where W = WAIT_VALID cycles up to and including the valid cycle.
- Latency, timeout run: busy high for RST_CYCLES + TIMEOUT + 1 cycles.
- Counters are sized clog2(TIMEOUT); no wrap occurs because the count is bounded by TIMEOUT-1.
- Async reset mid-run aborts immediately to the reset values; a partial result is discarded.

Decomposition:
- Shared package euler1_pkg:
  - state enum {IDLE, RESET_DUT, WAIT_VALID, READ, DONE}.
  - SLICE_W, NUM_SLICES, RESULT_W constants.
  - EXPECTED_RESULT = 18'd233168 for benches.
- One natural sub-module: euler1_slice_gather, a shift/insert register with slice index and settle counter, driven by a capture strobe.
- The FSM and timeout counter stay in the top.

Test Plan:
- Nominal: core model raises valid 10 cycles after dut_rst falls, slices {16,59,56} for mux_sel 0,1,2 -> result=233168, timeout_err=0, done pulses once, busy high 1+11+3+1=16 cycles.
- Timeout: dut_valid tied 0 -> done after RST_CYCLES+600+1 busy cycles, timeout_err=1, result=0, mux_sel never leaves 0.
- Edge of timeout: valid first asserted in the 600th WAIT_VALID cycle -> success, result=233168, timeout_err=0.
- Back-to-back: start held high, second run's core model returns slices {1,2,3} -> second done shows result=0x3081 (12417), with a dut_rst pulse between runs.
- Reset mid-READ: assert rst while mux_sel=1 -> all outputs at reset values, dut_rst=1 while rst is high; the next start yields a correct full result.
- Ignored start: pulse start during WAIT_VALID -> no extra dut_rst, run completes normally with a single done.
